quiz_judge_timer: RTL
=====================

Name: quiz_judge_timer

Overview:
- Host-side counterpart to the quiz-buzzer selector: consumes the selector's Timer_Start and Player_Number outputs.
- Runs the per-round answer countdown in whole seconds and accepts the host's Right/Wrong judgement keys.
- Maintains four saturating per-player scores and raises a timeout alarm.
- Sits between the selector and the display/buzzer drivers.

Parameters:
CLK_FREQ, 50_000_000, CLK cycles per one-second tick
ANSWER_SEC, 10, countdown start value in seconds (1..15)
ALARM_CYC, 25_000_000, cycles Alarm stays high on timeout
SCORE_MAX, 15, score saturation ceiling (fits 4 bits)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
Timer_Start  input  1  from selector; high once a player has buzzed in
Player_Number  input  4  from selector; 1..4 valid, others ignored
Judge_Right  input  1  host key, active-low, debounced
Judge_Wrong  input  1  host key, active-low, debounced
Score_Clr  input  1  active-high; clears all scores, honoured only in IDLE
Seconds_Left  output  4  remaining answer seconds
Active_Player  output  4  captured player number, 0 when idle
Score_Bus  output  16  scores {P4,P3,P2,P1}, 4 bits each
Time_Up  output  1  high in TIMEOUT state
Alarm  output  1  buzzer drive during timeout
Round_Done  output  1  high in DONE state

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset values:
  - Seconds_Left=0, Active_Player=0, Score_Bus=0, Time_Up=0, Alarm=0, Round_Done=0.
  - State IDLE; divider, alarm counter and edge registers cleared.
  - Reset mid-round aborts the round immediately and clears the scores.
- Edge detection: Timer_Start, Judge_Right and Judge_Wrong are registered once.
  - start_rise = Timer_Start & ~Timer_Start_d.
  - right_evt = ~Judge_Right & Judge_Right_d (falling edge); wrong_evt likewise.
- IDLE:
  - Score_Clr=1 clears Score_Bus at the next edge.
  - On start_rise with Player_Number in 1..4, at the same edge: Active_Player<=Player_Number, Seconds_Left<=ANSWER_SEC, divider<=0, go COUNT.
  - start_rise with an invalid number is ignored; the state stays IDLE.
- COUNT:
  - Divider counts 0..CLK_FREQ-1 and wraps. On wrap, Seconds_Left decrements.
  - The first decrement occurs exactly CLK_FREQ cycles after entering COUNT.
  - A decrement from 1 to 0 moves to TIMEOUT at the same edge.
  - right_evt: the active player's score increments (saturates at SCORE_MAX); go DONE.
  - wrong_evt: the active player's score decrements (saturates at 0); go DONE.
  - right_evt and wrong_evt in the same cycle: both ignored, stay COUNT.
  - Judge event coinciding with the final tick: the judge wins (score updated, DONE, no timeout).
  - Score_Clr is ignored.
- TIMEOUT:
  - Time_Up=1, Alarm=1 for ALARM_CYC cycles; no score change; then go DONE with Alarm=0.
  - Judge keys are ignored.
- DONE:
  - Round_Done=1; Seconds_Left and Active_Player are held.
  - When Timer_Start is sampled low, go IDLE and clear Active_Player and Seconds_Left.
- Timer_Start falling while in COUNT or TIMEOUT (host reset the selector): abort to IDLE next edge, no score change, Alarm=0.
- Scores persist across rounds; only RST or Score_Clr clears them.
- Outputs are all registered and decoded from state registers; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encoding (IDLE, COUNT, TIMEOUT, DONE), PLAYER_MIN=1, PLAYER_MAX=4, score-field width 4.
- Natural sub-module: sec_tick_gen, the CLK_FREQ divider with a synchronous clear and a one-cycle tick output. It is reusable by display blink logic.
- FSM, edge detectors and the score file stay in the top.

Test Plan (CLK_FREQ=10, ANSWER_SEC=3, ALARM_CYC=5):
1. Reset, then Timer_Start rises with Player_Number=2 → next edge Active_Player=2, Seconds_Left=3; after 10/20/30 cycles Seconds_Left=2/1/0; Time_Up=1 and Alarm=1 for 5 cycles; then Round_Done=1 and Score_Bus=0.
2. Player 3 buzzes; Judge_Right low pulse at cycle 4 → Score_Bus=16'h0100, Round_Done=1, Seconds_Left stays 3. Timer_Start low → IDLE, Active_Player=0.
3. Player 1 buzzes, Judge_Wrong with score 0 → score stays 0. Run 16 rounds of Right for player 4 → Score_Bus[15:12] saturates at 15.
4. Judge_Right and Judge_Wrong fall in the same cycle → no score change, still COUNT. Judge_Right on the exact cycle Seconds_Left hits 0 → score +1, Time_Up never asserts.
5. Timer_Start rises with Player_Number=0 or 5 → stays IDLE. Timer_Start drops mid-COUNT → IDLE, scores unchanged. Score_Clr in COUNT ignored; in IDLE clears Score_Bus=0.
6. RST asserted during TIMEOUT with scores nonzero → next edge Alarm=0, Score_Bus=0, state IDLE.

Source files
------------

// File: rtl/quiz_judge_timer_pkg.sv
// Shared types and constants for the quiz judge timer: FSM encoding,
// player numbering range and score field width.
package quiz_judge_timer_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCount   = 2'd1,
      StTimeout = 2'd2,
      StDone    = 2'd3
   } state_e;

   localparam int unsigned PLAYER_MIN  = 1;
   localparam int unsigned PLAYER_MAX  = 4;
   localparam int unsigned NUM_PLAYERS = PLAYER_MAX - PLAYER_MIN + 1;
   localparam int unsigned SCORE_W     = 4;

   function automatic logic player_valid(input logic [3:0] num);
      return (num >= 4'(PLAYER_MIN)) && (num <= 4'(PLAYER_MAX));
   endfunction

endpackage

// File: rtl/quiz_judge_timer_sec_tick_gen.sv
// One-second tick generator: counts 0..CLK_FREQ-1 while enabled and pulses
// tick_o for one cycle on the wrapping cycle. clr_i holds the count at zero.
module quiz_judge_timer_sec_tick_gen #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_FREQ - 1);

   logic [CntW-1:0] cnt_d, cnt_q;
   logic            wrap;

   always_comb begin
      wrap  = en_i && (cnt_q == CntLast);
      cnt_d = cnt_q;
      if (clr_i || wrap) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = wrap & ~clr_i;

endmodule

// File: rtl/quiz_judge_timer.sv
// Answer countdown, judge-key handling and saturating score file that sit
// behind the quiz-buzzer selector. All outputs are decoded from flops.
module quiz_judge_timer
   import quiz_judge_timer_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned ANSWER_SEC = 10,
   parameter int unsigned ALARM_CYC  = 25_000_000,
   parameter int unsigned SCORE_MAX  = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Timer_Start,
   input  logic [3:0]  Player_Number,
   input  logic        Judge_Right,
   input  logic        Judge_Wrong,
   input  logic        Score_Clr,
   output logic [3:0]  Seconds_Left,
   output logic [3:0]  Active_Player,
   output logic [15:0] Score_Bus,
   output logic        Time_Up,
   output logic        Alarm,
   output logic        Round_Done
);

   localparam int unsigned AlW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
   localparam logic [AlW-1:0]     AlLast   = AlW'(ALARM_CYC - 1);
   localparam logic [3:0]         SecsInit = 4'(ANSWER_SEC);
   localparam logic [SCORE_W-1:0] ScoreMax = SCORE_W'(SCORE_MAX);

   state_e                                state_d, state_q;
   logic [3:0]                            secs_d, secs_q;
   logic [3:0]                            player_d, player_q;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_d, score_q;
   logic [AlW-1:0]                        alarm_cnt_d, alarm_cnt_q;
   logic                                  ts_q, jr_q, jw_q;

   logic       start_rise, right_evt, wrong_evt, judge_one, tick;
   logic [1:0] idx;

   quiz_judge_timer_sec_tick_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_sec_tick_gen (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (state_q != StCount),
      .en_i   (state_q == StCount),
      .tick_o (tick)
   );

   always_comb begin
      start_rise = Timer_Start & ~ts_q;
      right_evt  = ~Judge_Right & jr_q;
      wrong_evt  = ~Judge_Wrong & jw_q;
      // Simultaneous right and wrong cancel each other out.
      judge_one  = right_evt ^ wrong_evt;
      idx        = 2'(player_q - 4'(PLAYER_MIN));

      state_d     = state_q;
      secs_d      = secs_q;
      player_d    = player_q;
      score_d     = score_q;
      alarm_cnt_d = '0;

      unique case (state_q)
         StIdle: begin
            if (Score_Clr) begin
               score_d = '0;
            end
            if (start_rise && player_valid(Player_Number)) begin
               player_d = Player_Number;
               secs_d   = SecsInit;
               state_d  = StCount;
            end
         end
         StCount: begin
            if (!Timer_Start) begin
               state_d  = StIdle;
               secs_d   = '0;
               player_d = '0;
            end else if (judge_one) begin
               // Judge takes priority over a coincident final tick.
               if (right_evt) begin
                  if (score_q[idx] < ScoreMax) score_d[idx] = score_q[idx] + SCORE_W'(1);
               end else begin
                  if (score_q[idx] != '0) score_d[idx] = score_q[idx] - SCORE_W'(1);
               end
               state_d = StDone;
            end else if (tick) begin
               secs_d = secs_q - 4'd1;
               if (secs_q == 4'd1) state_d = StTimeout;
            end
         end
         StTimeout: begin
            if (!Timer_Start) begin
               state_d  = StIdle;
               secs_d   = '0;
               player_d = '0;
            end else if (alarm_cnt_q == AlLast) begin
               state_d = StDone;
            end else begin
               alarm_cnt_d = alarm_cnt_q + AlW'(1);
            end
         end
         StDone: begin
            if (!Timer_Start) begin
               state_d  = StIdle;
               secs_d   = '0;
               player_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         secs_q      <= '0;
         player_q    <= '0;
         score_q     <= '0;
         alarm_cnt_q <= '0;
         ts_q        <= 1'b0;
         jr_q        <= 1'b0;
         jw_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         secs_q      <= secs_d;
         player_q    <= player_d;
         score_q     <= score_d;
         alarm_cnt_q <= alarm_cnt_d;
         ts_q        <= Timer_Start;
         jr_q        <= Judge_Right;
         jw_q        <= Judge_Wrong;
      end
   end

   assign Seconds_Left  = secs_q;
   assign Active_Player = player_q;
   assign Score_Bus     = score_q;
   assign Time_Up       = (state_q == StTimeout);
   assign Alarm         = (state_q == StTimeout);
   assign Round_Done    = (state_q == StDone);

endmodule
